// File: rtl/br_resolve_queue_if.sv
// Fetch/execute-facing signal bundle of the branch resolve queue.
// Handshake: an enqueue happens on an edge where enq_valid & enq_ready (and EN); exe_valid is a one-shot retire request with no ready.
interface br_resolve_queue_if #(
  parameter int W     = 32,
  parameter int PTR_W = 3
);
  logic             enq_valid;
  logic [W-1:0]     enq_pc;
  logic             enq_pred_taken;
  logic             enq_hit;
  logic [W-1:0]     enq_target;
  logic             enq_ready;
  logic             exe_valid;
  logic             exe_taken;
  logic [W-1:0]     exe_target;
  logic             resolve;
  logic [W-1:0]     PC_addr;
  logic             pr_br_taken;
  logic             pr_hit;
  logic [W-1:0]     pr_TARGET;
  logic             redirect;
  logic [W-1:0]     redirect_pc;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;

  modport master (
    output enq_valid, enq_pc, enq_pred_taken, enq_hit, enq_target,
    output exe_valid, exe_taken, exe_target,
    input  enq_ready, resolve, PC_addr, pr_br_taken, pr_hit, pr_TARGET,
    input  redirect, redirect_pc, count, full, empty
  );

  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, enq_hit, enq_target,
    input  exe_valid, exe_taken, exe_target,
    output enq_ready, resolve, PC_addr, pr_br_taken, pr_hit, pr_TARGET,
    output redirect, redirect_pc, count, full, empty
  );
endinterface

// File: rtl/br_resolve_queue.sv
// In-order queue of in-flight branch predictions; retires the oldest on execute
// resolution, drives the BTB update port and raises a redirect on mispredict.
module br_resolve_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  br_resolve_queue_if.slave  q
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]   pc_mem     [DEPTH];
  logic [W-1:0]   target_mem [DEPTH];
  logic           pt_mem     [DEPTH];
  logic           hit_mem    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count_r;

  logic           enq_fire, deq_fire, mispredict;
  logic [W-1:0]   head_pc, head_pc4, head_target;
  logic           head_pt;

  assign q.count     = count_r;
  assign q.full      = (count_r == FULL_CNT);
  assign q.empty     = (count_r == '0);
  assign q.enq_ready = !q.full;

  assign enq_fire = EN & q.enq_valid & q.enq_ready;
  assign deq_fire = EN & q.exe_valid & !q.empty;

  assign head_pc     = pc_mem[head];
  assign head_pc4    = head_pc + W'(4);
  assign head_target = target_mem[head];
  assign head_pt     = pt_mem[head];

  // A taken-predicted branch that is taken to a different place is still wrong.
  assign mispredict = (head_pt != q.exe_taken) |
                      (head_pt & q.exe_taken & (head_target != q.exe_target));

  // Entry storage carries no reset; occupancy is tracked solely by count_r.
  always_ff @(posedge clk) begin
    if (enq_fire && !(deq_fire && mispredict)) begin
      pc_mem[tail]     <= q.enq_pc;
      target_mem[tail] <= q.enq_target;
      pt_mem[tail]     <= q.enq_pred_taken;
      hit_mem[tail]    <= q.enq_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head          <= '0;
      tail          <= '0;
      count_r       <= '0;
      q.resolve     <= 1'b0;
      q.redirect    <= 1'b0;
      q.pr_br_taken <= 1'b0;
      q.pr_hit      <= 1'b0;
      q.PC_addr     <= '0;
      q.pr_TARGET   <= '0;
      q.redirect_pc <= '0;
    end else begin
      q.resolve  <= deq_fire;
      q.redirect <= deq_fire & mispredict;

      if (deq_fire) begin
        q.PC_addr     <= head_pc;
        q.pr_br_taken <= q.exe_taken;
        q.pr_hit      <= hit_mem[head];
        q.pr_TARGET   <= q.exe_taken ? q.exe_target : head_target;
      end

      if (deq_fire && mispredict) begin
        // Flush everything younger; a same-cycle enqueue is dropped.
        q.redirect_pc <= q.exe_taken ? q.exe_target : head_pc4;
        head          <= head + 1'b1;
        tail          <= head + 1'b1;
        count_r       <= '0;
      end else begin
        if (deq_fire) head <= head + 1'b1;
        if (enq_fire) tail <= tail + 1'b1;
        if (enq_fire && !deq_fire)      count_r <= count_r + 1'b1;
        else if (deq_fire && !enq_fire) count_r <= count_r - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed bench for br_resolve_queue: fill/full, correct and mispredicted
// retires, flush vs enqueue, enable freeze, back-to-back retires, wrap and reset.
module tb_br_resolve_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic EN  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  br_resolve_queue_if #(.W(32), .PTR_W(3)) q_if ();

  br_resolve_queue #(.W(32), .DEPTH(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .EN  (EN),
    .q   (q_if.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // driver tasks: inputs change 1ns after the rising edge, outputs are read there too
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_enq(input logic [31:0] pc, input logic pt, input logic hit, input logic [31:0] tgt);
    q_if.enq_valid = 1'b1; q_if.enq_pc = pc; q_if.enq_pred_taken = pt;
    q_if.enq_hit = hit; q_if.enq_target = tgt;
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0;
  endtask

  task automatic drive_retire(input logic taken, input logic [31:0] tgt);
    q_if.exe_valid = 1'b1; q_if.exe_taken = taken; q_if.exe_target = tgt;
    @(posedge clk); #1;
    q_if.exe_valid = 1'b0;
  endtask

  task automatic drive_both(input logic [31:0] pc, input logic pt, input logic taken, input logic [31:0] tgt);
    q_if.enq_valid = 1'b1; q_if.enq_pc = pc; q_if.enq_pred_taken = pt;
    q_if.enq_hit = 1'b0; q_if.enq_target = 32'h0;
    q_if.exe_valid = 1'b1; q_if.exe_taken = taken; q_if.exe_target = tgt;
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0; q_if.exe_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (q_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", q_if.empty); end
    checks++; if (q_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", q_if.full); end
    #1 rst = 1'b1;
    EN = 1'b1;
    idle(2);
    checks++; if (q_if.count !== 4'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", q_if.count); end
    checks++; if (q_if.enq_ready !== 1'b1) begin errors++; $display("FAIL idle_enq_ready: got %b expected 1", q_if.enq_ready); end
    checks++; if (q_if.resolve !== 1'b0 || q_if.redirect !== 1'b0) begin errors++; $display("FAIL idle_strobes: got %b%b expected 00", q_if.resolve, q_if.redirect); end
    checks++; if (q_if.PC_addr !== 32'h0 || q_if.redirect_pc !== 32'h0 || q_if.pr_TARGET !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h %h %h expected zeros", q_if.PC_addr, q_if.redirect_pc, q_if.pr_TARGET); end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 8; i++) begin
      drive_enq(32'h120 + 32'(i) * 32'h100, 1'b1, 1'b0, 32'hAAAAAAAA);
      exp_q.push_back(32'h120 + 32'(i) * 32'h100);
    end
    checks++; if (q_if.count !== 4'd8 || q_if.full !== 1'b1) begin errors++; $display("FAIL fill_count: got %0d/%b expected 8/1", q_if.count, q_if.full); end
    drive_enq(32'h920, 1'b1, 1'b0, 32'hAAAAAAAA);
    checks++; if (q_if.count !== 4'd8 || q_if.enq_ready !== 1'b0) begin errors++; $display("FAIL full_block: got %0d/%b expected 8/0", q_if.count, q_if.enq_ready); end
    drive_retire(1'b1, 32'hAAAAAAAA);
    exp_pc = exp_q.pop_front();
    checks++; if (q_if.count !== 4'd7 || q_if.enq_ready !== 1'b1) begin errors++; $display("FAIL retire_one: got %0d/%b expected 7/1", q_if.count, q_if.enq_ready); end
    checks++; if (q_if.resolve !== 1'b1 || q_if.PC_addr !== exp_pc) begin errors++; $display("FAIL retire_one_pc: got %b/%h expected 1/%h", q_if.resolve, q_if.PC_addr, exp_pc); end
    for (int i = 0; i < 7; i++) begin
      drive_retire(1'b1, 32'hAAAAAAAA);
      exp_pc = exp_q.pop_front();
      checks++; if (q_if.resolve !== 1'b1 || q_if.redirect !== 1'b0 || q_if.PC_addr !== exp_pc) begin errors++; $display("FAIL drain_order: got %b%b/%h expected 10/%h", q_if.resolve, q_if.redirect, q_if.PC_addr, exp_pc); end
    end
    idle(1);
    checks++; if (q_if.resolve !== 1'b0 || q_if.empty !== 1'b1) begin errors++; $display("FAIL drain_end: got %b/%b expected 0/1", q_if.resolve, q_if.empty); end
  endtask

  task automatic test_correct();
    drive_enq(32'h130, 1'b1, 1'b1, 32'hBBBBBBBB);
    drive_retire(1'b1, 32'hBBBBBBBB);
    checks++; if (q_if.resolve !== 1'b1 || q_if.PC_addr !== 32'h130 || q_if.pr_br_taken !== 1'b1 || q_if.pr_hit !== 1'b1) begin errors++; $display("FAIL correct_port: got %b %h %b %b expected 1 130 1 1", q_if.resolve, q_if.PC_addr, q_if.pr_br_taken, q_if.pr_hit); end
    checks++; if (q_if.pr_TARGET !== 32'hBBBBBBBB || q_if.redirect !== 1'b0) begin errors++; $display("FAIL correct_target: got %h/%b expected bbbbbbbb/0", q_if.pr_TARGET, q_if.redirect); end
  endtask

  task automatic test_mispredict_dir();
    drive_enq(32'h230, 1'b0, 1'b0, 32'h0);
    drive_enq(32'h330, 1'b1, 1'b0, 32'h12345678);
    drive_retire(1'b1, 32'hCCCCCCCC);
    checks++; if (q_if.redirect !== 1'b1 || q_if.redirect_pc !== 32'hCCCCCCCC) begin errors++; $display("FAIL mp_dir_redirect: got %b/%h expected 1/cccccccc", q_if.redirect, q_if.redirect_pc); end
    checks++; if (q_if.count !== 4'd0 || q_if.empty !== 1'b1 || q_if.PC_addr !== 32'h230) begin errors++; $display("FAIL mp_dir_flush: got %0d/%b/%h expected 0/1/230", q_if.count, q_if.empty, q_if.PC_addr); end
    drive_retire(1'b1, 32'hCCCCCCCC);
    checks++; if (q_if.resolve !== 1'b0 || q_if.redirect !== 1'b0 || q_if.redirect_pc !== 32'hCCCCCCCC) begin errors++; $display("FAIL mp_dir_empty_exe: got %b%b/%h expected 00/cccccccc", q_if.resolve, q_if.redirect, q_if.redirect_pc); end
  endtask

  task automatic test_mispredict_target();
    drive_enq(32'h430, 1'b1, 1'b0, 32'hDDDDDDDD);
    drive_retire(1'b0, 32'h55555555);
    checks++; if (q_if.redirect !== 1'b1 || q_if.redirect_pc !== 32'h434) begin errors++; $display("FAIL mp_nt_redirect: got %b/%h expected 1/434", q_if.redirect, q_if.redirect_pc); end
    checks++; if (q_if.pr_br_taken !== 1'b0 || q_if.pr_TARGET !== 32'hDDDDDDDD) begin errors++; $display("FAIL mp_nt_port: got %b/%h expected 0/dddddddd", q_if.pr_br_taken, q_if.pr_TARGET); end
    drive_enq(32'h440, 1'b1, 1'b0, 32'hDDDDDDDD);
    drive_retire(1'b1, 32'hEEEEEEEE);
    checks++; if (q_if.redirect !== 1'b1 || q_if.redirect_pc !== 32'hEEEEEEEE || q_if.pr_TARGET !== 32'hEEEEEEEE) begin errors++; $display("FAIL mp_tgt: got %b/%h/%h expected 1/eeeeeeee/eeeeeeee", q_if.redirect, q_if.redirect_pc, q_if.pr_TARGET); end
    drive_enq(32'hFFFFFFFC, 1'b1, 1'b0, 32'h100);
    drive_retire(1'b0, 32'h0);
    checks++; if (q_if.redirect !== 1'b1 || q_if.redirect_pc !== 32'h0) begin errors++; $display("FAIL mp_pc4_wrap: got %b/%h expected 1/00000000", q_if.redirect, q_if.redirect_pc); end
  endtask

  task automatic test_enq_flush();
    drive_enq(32'h530, 1'b0, 1'b0, 32'h0);
    drive_both(32'h630, 1'b0, 1'b1, 32'h1000);
    checks++; if (q_if.redirect !== 1'b1 || q_if.redirect_pc !== 32'h1000 || q_if.count !== 4'd0) begin errors++; $display("FAIL flush_wins: got %b/%h/%0d expected 1/1000/0", q_if.redirect, q_if.redirect_pc, q_if.count); end
    drive_retire(1'b0, 32'h0);
    checks++; if (q_if.resolve !== 1'b0) begin errors++; $display("FAIL flush_dropped_enq: got %b expected 0", q_if.resolve); end
  endtask

  task automatic test_en_freeze();
    drive_enq(32'h600, 1'b0, 1'b1, 32'h0);
    EN = 1'b0;
    q_if.enq_valid = 1'b1; q_if.enq_pc = 32'h610; q_if.exe_valid = 1'b1; q_if.exe_taken = 1'b1;
    @(posedge clk); #1;
    q_if.enq_valid = 1'b0; q_if.exe_valid = 1'b0;
    checks++; if (q_if.count !== 4'd1 || q_if.resolve !== 1'b0 || q_if.redirect !== 1'b0) begin errors++; $display("FAIL en_freeze: got %0d/%b%b expected 1/00", q_if.count, q_if.resolve, q_if.redirect); end
    EN = 1'b1;
    drive_retire(1'b0, 32'h0);
    checks++; if (q_if.resolve !== 1'b1 || q_if.PC_addr !== 32'h600 || q_if.pr_hit !== 1'b1 || q_if.count !== 4'd0) begin errors++; $display("FAIL en_resume: got %b/%h/%b/%0d expected 1/600/1/0", q_if.resolve, q_if.PC_addr, q_if.pr_hit, q_if.count); end
  endtask

  task automatic test_back_to_back();
    drive_enq(32'h700, 1'b0, 1'b0, 32'h0);
    drive_enq(32'h710, 1'b0, 1'b0, 32'h0);
    drive_both(32'h720, 1'b0, 1'b0, 32'h0);
    checks++; if (q_if.count !== 4'd2 || q_if.resolve !== 1'b1 || q_if.PC_addr !== 32'h700) begin errors++; $display("FAIL enq_deq_same: got %0d/%b/%h expected 2/1/700", q_if.count, q_if.resolve, q_if.PC_addr); end
    checks++; if (q_if.redirect !== 1'b0 || q_if.redirect_pc !== 32'h1000) begin errors++; $display("FAIL redirect_pc_hold: got %b/%h expected 0/1000", q_if.redirect, q_if.redirect_pc); end
    drive_retire(1'b0, 32'h0);
    checks++; if (q_if.resolve !== 1'b1 || q_if.PC_addr !== 32'h710) begin errors++; $display("FAIL b2b_first: got %b/%h expected 1/710", q_if.resolve, q_if.PC_addr); end
    drive_retire(1'b0, 32'h0);
    checks++; if (q_if.resolve !== 1'b1 || q_if.PC_addr !== 32'h720 || q_if.count !== 4'd0) begin errors++; $display("FAIL b2b_second: got %b/%h/%0d expected 1/720/0", q_if.resolve, q_if.PC_addr, q_if.count); end
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 0; i < 5; i++) begin
      drive_enq(32'h800 + 32'(i) * 32'h10, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h800 + 32'(i) * 32'h10);
    end
    for (int i = 0; i < 3; i++) begin
      drive_retire(1'b0, 32'h0);
      exp_pc = exp_q.pop_front();
      checks++; if (q_if.PC_addr !== exp_pc) begin errors++; $display("FAIL wrap_order_a: got %h expected %h", q_if.PC_addr, exp_pc); end
    end
    for (int i = 0; i < 6; i++) begin
      drive_enq(32'h900 + 32'(i) * 32'h10, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h900 + 32'(i) * 32'h10);
    end
    checks++; if (q_if.count !== 4'd8 || q_if.full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %0d/%b expected 8/1", q_if.count, q_if.full); end
    for (int i = 0; i < 4; i++) begin
      drive_retire(1'b0, 32'h0);
      exp_pc = exp_q.pop_front();
      checks++; if (q_if.PC_addr !== exp_pc || q_if.resolve !== 1'b1) begin errors++; $display("FAIL wrap_order_b: got %b/%h expected 1/%h", q_if.resolve, q_if.PC_addr, exp_pc); end
    end
    rst = 1'b0;
    #1;
    checks++; if (q_if.count !== 4'd0 || q_if.empty !== 1'b1 || q_if.resolve !== 1'b0 || q_if.redirect !== 1'b0) begin errors++; $display("FAIL async_reset: got %0d/%b/%b%b expected 0/1/00", q_if.count, q_if.empty, q_if.resolve, q_if.redirect); end
    exp_q.delete();
    #1 rst = 1'b1;
    idle(1);
    drive_retire(1'b0, 32'h0);
    checks++; if (q_if.resolve !== 1'b0 || q_if.count !== 4'd0) begin errors++; $display("FAIL post_reset_empty: got %b/%0d expected 0/0", q_if.resolve, q_if.count); end
  endtask

  initial begin
    q_if.enq_valid = 1'b0; q_if.enq_pc = '0; q_if.enq_pred_taken = 1'b0;
    q_if.enq_hit = 1'b0; q_if.enq_target = '0;
    q_if.exe_valid = 1'b0; q_if.exe_taken = 1'b0; q_if.exe_target = '0;
    test_reset();
    test_fill_full();
    test_correct();
    test_mispredict_dir();
    test_mispredict_target();
    test_enq_flush();
    test_en_freeze();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_resolve_queue.md
Name: br_resolve_queue

Overview:
- In-order queue of in-flight branch predictions. Sits between the fetch-side BTB/predictor and execute.
- Each fetch-time prediction is enqueued with its PC, predicted direction, BTB hit and predicted target.
- When execute resolves the oldest branch, the block compares the actual outcome with the prediction and drives the BTB update port (resolve, pr_br_taken, pr_hit, pr_TARGET, PC).
- On a mispredict it raises a one-cycle redirect and flushes all younger entries.

Parameters:
- W, 32, address/target width
- DEPTH, 8, queue entries (power of two)
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- EN  input  1  global enable; 0 freezes all state
- enq_valid  input  1  fetch presents a predicted branch
- enq_pc  input  W  branch PC
- enq_pred_taken  input  1  predicted direction
- enq_hit  input  1  BTB HIT at prediction time
- enq_target  input  W  BTB TARGET at prediction time
- enq_ready  output  1  queue can accept (= !full)
- exe_valid  input  1  execute resolves the oldest branch
- exe_taken  input  1  actual direction
- exe_target  input  W  actual taken target
- resolve  output  1  one-cycle BTB update strobe
- PC_addr  output  W  PC of the resolved branch
- pr_br_taken  output  1  actual direction, to BTB
- pr_hit  output  1  stored enq_hit of the resolved entry
- pr_TARGET  output  W  exe_target of the resolved entry
- redirect  output  1  one-cycle mispredict strobe
- redirect_pc  output  W  correct next fetch PC
- count  output  PTR_W+1  occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail and count go to 0; empty=1, full=0.
  - resolve, redirect, pr_br_taken and pr_hit go to 0.
  - PC_addr, pr_TARGET and redirect_pc go to 0.
  - All entry valid state is cleared.
- Reset asserted mid-operation discards all entries immediately.
- EN=0:
  - No enqueue and no dequeue.
  - resolve and redirect are 0 on the next edge.
  - count holds.
- Enqueue: on a clk edge with EN & enq_valid & enq_ready, the entry is written at tail and tail increments modulo DEPTH. Wrap from DEPTH-1 to 0 is natural pointer overflow.
- enq_ready = !full, combinational from count only. When full, no enqueue occurs even if a dequeue happens in the same cycle.
- Dequeue: on a clk edge with EN & exe_valid & !empty, the head entry retires and head increments modulo DEPTH.
- exe_valid while empty is ignored: no strobe, no state change.
- Registered outputs, valid the cycle after the retire edge (latency 1):
  - resolve = 1
  - PC_addr = entry pc
  - pr_br_taken = exe_taken
  - pr_hit = entry hit
  - pr_TARGET = exe_target if exe_taken, else entry target
- resolve is high for exactly one cycle per retire. Back-to-back retires give back-to-back strobes.
- Predicted next PC of an entry:
  - pred_taken=1: entry target
  - pred_taken=0: pc+4, W-bit wraparound
- Mispredict when either holds:
  - pred_taken != exe_taken
  - pred_taken = exe_taken = 1 and entry target != exe_target
- On mispredict, in the cycle after retire:
  - redirect = 1
  - redirect_pc = exe_target if exe_taken, else pc+4
  - On the retire edge, all remaining entries are flushed: tail = head+1, count = 0.
  - An enqueue in the same cycle is dropped.
- Correct prediction: redirect = 0 and redirect_pc holds its last value.
- Simultaneous enqueue and correct-prediction dequeue (not full): count unchanged, both pointers advance.
- Simultaneous enqueue and mispredict dequeue: flush wins, count = 0.
- count, full and empty are derived from the registered count, which updates on the clock edge.

Test Plan:
- Reset, then EN=1 with no stimulus -> empty=1, count=0, enq_ready=1, resolve=0, redirect=0.
- Enqueue 8 entries with pc=0x120..0x820 step 0x100, all pred_taken=1, hit=0, target=0xAAAAAAAA. Then a 9th enq_valid -> full=1, enq_ready=0, count stays 8. Then retire one -> count=7, enq_ready=1.
- Enqueue pc=0x130 (pred_taken=1, hit=1, target=0xBBBBBBBB); retire with exe_taken=1, exe_target=0xBBBBBBBB -> next cycle: resolve=1, PC_addr=0x130, pr_br_taken=1, pr_hit=1, pr_TARGET=0xBBBBBBBB, redirect=0.
- Enqueue 0x230 (pred_taken=0) and 0x330; retire 0x230 with exe_taken=1, exe_target=0xCCCCCCCC -> redirect=1, redirect_pc=0xCCCCCCCC, count=0. A following exe_valid produces no resolve.
- Enqueue 0x430 (pred_taken=1, target=0xDDDDDDDD); retire with exe_taken=0 -> redirect=1, redirect_pc=0x434, pr_br_taken=0, pr_TARGET=0xDDDDDDDD.
- Fill 5 entries, retire 3, enqueue 6 more -> tail wraps past DEPTH-1 and retire order matches enqueue order. Then assert rst low mid-stream -> count=0 and all strobes 0 asynchronously.
